// File: rtl/pc_seq_pkg.sv
// Shared encodings for the multicycle PC sequencer: opcodes, FSM states, instruction classes.
// PC_SEQ_SYSTEM_HALT_EN makes the SYSTEM opcode decode to its own class instead of illegal.
package pc_seq_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Bit positions inside pc_control = {reset, enable, pc_src, jalr}
    localparam int PCC_RESET = 3;
    localparam int PCC_EN    = 2;
    localparam int PCC_SRC   = 1;
    localparam int PCC_JALR  = 0;

    typedef enum logic [2:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_TRAP,
        S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_NONE,
        C_LUI,
        C_AUIPC,
        C_JAL,
        C_JALR,
        C_BRANCH,
        C_LOAD,
        C_STORE,
        C_OPIMM,
        C_OP,
        C_SYSTEM,
        C_ILLEGAL
    } instr_class_t;

    typedef enum logic [1:0] {
        TC_NONE    = 2'b00,
        TC_ILLEGAL = 2'b01,
        TC_TIMEOUT = 2'b10
    } trap_cause_t;

    function automatic instr_class_t decode_class(input logic [6:0] op);
        instr_class_t c;
        case (op)
            OP_LUI:    c = C_LUI;
            OP_AUIPC:  c = C_AUIPC;
            OP_JAL:    c = C_JAL;
            OP_JALR:   c = C_JALR;
            OP_BRANCH: c = C_BRANCH;
            OP_LOAD:   c = C_LOAD;
            OP_STORE:  c = C_STORE;
            OP_IMM:    c = C_OPIMM;
            OP_OP:     c = C_OP;
`ifdef PC_SEQ_SYSTEM_HALT_EN
            OP_SYSTEM: c = C_SYSTEM;
`endif
            default:   c = C_ILLEGAL;
        endcase
        return c;
    endfunction

    // Classes that retire with a register-file write
    function automatic logic writes_rd(input instr_class_t c);
        return (c == C_LUI) || (c == C_AUIPC) || (c == C_JAL) || (c == C_JALR) ||
               (c == C_LOAD) || (c == C_OPIMM) || (c == C_OP);
    endfunction

endpackage

// File: rtl/pc_sequencer_branch_resolver.sv
// Combinational branch condition evaluation from funct3 and the ALU compare flags.
// o_valid is low for the two funct3 codes RV32I leaves unassigned for branches.
module branch_resolver (
    input  logic [2:0] i_funct3,
    input  logic       i_cmp_eq,
    input  logic       i_cmp_lt,
    input  logic       i_cmp_ltu,
    output logic       o_taken,
    output logic       o_valid
);

    always_comb begin
        o_taken = 1'b0;
        o_valid = 1'b1;
        case (i_funct3)
            3'b000:  o_taken = i_cmp_eq;
            3'b001:  o_taken = !i_cmp_eq;
            3'b100:  o_taken = i_cmp_lt;
            3'b101:  o_taken = !i_cmp_lt;
            3'b110:  o_taken = i_cmp_ltu;
            3'b111:  o_taken = !i_cmp_ltu;
            default: o_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle RV32I control FSM driving the PC control bus, IR latch and register-file write.
// Define PC_SEQ_SYSTEM_HALT_EN to make SYSTEM instructions halt instead of trapping.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mem_ready,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       cmp_eq,
    input  logic       cmp_lt,
    input  logic       cmp_ltu,
    output logic [3:0] pc_control,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic       halted
);

    localparam int WAIT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);

    state_t             r_state;
    instr_class_t       r_class;
    logic               r_taken;
    logic [WAIT_W-1:0]  r_wait;
    logic               r_trap;
    trap_cause_t        r_cause;

    instr_class_t       w_class;
    logic               w_br_taken;
    logic               w_br_valid;
    logic [WAIT_W-1:0]  w_wait_inc;
    logic               w_timeout;

    branch_resolver u_branch (
        .i_funct3  (funct3),
        .i_cmp_eq  (cmp_eq),
        .i_cmp_lt  (cmp_lt),
        .i_cmp_ltu (cmp_ltu),
        .o_taken   (w_br_taken),
        .o_valid   (w_br_valid)
    );

    assign w_class    = decode_class(opcode);
    assign w_wait_inc = (r_wait == '1) ? r_wait : r_wait + WAIT_W'(1);
    // The current stalled cycle is wait number r_wait+1; trap when that hits the limit
    assign w_timeout  = (MEM_WAIT_MAX != 0) && ((32'(r_wait) + 32'd1) >= MEM_WAIT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RESET;
            r_class <= C_NONE;
            r_taken <= 1'b0;
            r_wait  <= '0;
            r_trap  <= 1'b0;
            r_cause <= TC_NONE;
        end else begin
            case (r_state)
                S_RESET: r_state <= S_FETCH;
                S_FETCH: begin
                    if (mem_ready) begin
                        r_state <= S_DECODE;
                        r_wait  <= '0;
                    end else if (w_timeout) begin
                        r_state <= S_TRAP;
                        r_trap  <= 1'b1;
                        r_cause <= TC_TIMEOUT;
                        r_wait  <= '0;
                    end else begin
                        r_wait  <= w_wait_inc;
                    end
                end
                S_DECODE: begin
                    r_class <= w_class;
                    if (w_class == C_ILLEGAL || (w_class == C_BRANCH && !w_br_valid)) begin
                        r_state <= S_TRAP;
                        r_trap  <= 1'b1;
                        r_cause <= TC_ILLEGAL;
                    end
`ifdef PC_SEQ_SYSTEM_HALT_EN
                    else if (w_class == C_SYSTEM) begin
                        r_state <= S_HALT;
                    end
`endif
                    else begin
                        r_state <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    r_taken <= w_br_taken;
                    r_state <= (r_class == C_LOAD || r_class == C_STORE) ? S_MEMORY : S_WRITEBACK;
                end
                S_MEMORY: begin
                    if (mem_ready) begin
                        r_state <= S_WRITEBACK;
                        r_wait  <= '0;
                    end else if (w_timeout) begin
                        r_state <= S_TRAP;
                        r_trap  <= 1'b1;
                        r_cause <= TC_TIMEOUT;
                        r_wait  <= '0;
                    end else begin
                        r_wait  <= w_wait_inc;
                    end
                end
                S_WRITEBACK: r_state <= S_FETCH;
                S_TRAP:      r_state <= S_TRAP;
                S_HALT:      r_state <= S_HALT;
                default:     r_state <= S_RESET;
            endcase
        end
    end

    // Moore decode of the registered state; ir_write alone follows mem_ready in FETCH
    always_comb begin
        pc_control = '0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        case (r_state)
            S_RESET: pc_control[PCC_RESET] = 1'b1;
            S_FETCH: begin
                mem_read = 1'b1;
                ir_write = mem_ready;
            end
            S_MEMORY: begin
                mem_read  = (r_class == C_LOAD);
                mem_write = (r_class == C_STORE);
            end
            S_WRITEBACK: begin
                pc_control[PCC_EN]   = 1'b1;
                pc_control[PCC_SRC]  = (r_class == C_JAL) || (r_class == C_BRANCH && r_taken);
                pc_control[PCC_JALR] = (r_class == C_JALR);
                reg_write            = writes_rd(r_class);
            end
            default: ;
        endcase
    end

    assign trap       = r_trap;
    assign trap_cause = r_cause;

`ifdef PC_SEQ_SYSTEM_HALT_EN
    assign halted = (r_state == S_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule
